// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU codes, opcode/funct constants,
// branch encoding and the control bundle produced by the ID decoder.
package mips_pkg;

  // ALU operation codes consumed by EX
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_NOR  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_ANDI = 5'b00110;
  localparam logic [4:0] ALU_XORI = 5'b00111;
  localparam logic [4:0] ALU_ORI  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10001;
  localparam logic [4:0] ALU_SRA  = 5'b10010;
  localparam logic [4:0] ALU_SLT  = 5'b10011;
  localparam logic [4:0] ALU_SLTU = 5'b10100;
  localparam logic [4:0] ALU_ADDU = 5'b10101;
  localparam logic [4:0] ALU_SUBU = 5'b10110;
  localparam logic [4:0] ALU_LUI  = 5'b10111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Branch encoding
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  // Control fields that are forced to zero whenever the EX slot is empty
  typedef struct packed {
    logic [4:0] alu_code;
    logic       a_sel;
    logic       b_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [1:0] branch;
  } ctrl_t;

  // Full decode result of one instruction word
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic        uses_rs;
    logic        uses_rt;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  // Common shape of an immediate-operand instruction writing rt
  function automatic dec_t itype(input logic [4:0] code, input logic [31:0] imm,
                                 input logic [4:0] dst);
    dec_t d;
    d = '0;
    d.ctrl.alu_code  = code;
    d.ctrl.b_sel     = 1'b1;
    d.ctrl.reg_write = 1'b1;
    d.imm            = imm;
    d.rd             = dst;
    d.uses_rs        = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of a 32-bit MIPS instruction into the ID/EX control bundle.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op_s;
  logic [5:0] fn_s;

  assign op_s = instr[31:26];
  assign fn_s = instr[5:0];

  // Opcode/funct to ALU code, operand selects, immediate and side-effect controls
  always_comb begin
    dec = '0;
    case (op_s)
      OP_RTYPE: begin
        dec.rd             = instr[15:11];
        dec.ctrl.reg_write = (instr[15:11] != 5'd0);
        dec.uses_rs        = 1'b1;
        dec.uses_rt        = 1'b1;
        case (fn_s)
          F_SLL:  begin dec.ctrl.alu_code = ALU_SLL; dec.ctrl.a_sel = 1'b1; dec.uses_rs = 1'b0; end
          F_SRL:  begin dec.ctrl.alu_code = ALU_SRL; dec.ctrl.a_sel = 1'b1; dec.uses_rs = 1'b0; end
          F_SRA:  begin dec.ctrl.alu_code = ALU_SRA; dec.ctrl.a_sel = 1'b1; dec.uses_rs = 1'b0; end
          F_SLLV: dec.ctrl.alu_code = ALU_SLL;
          F_SRLV: dec.ctrl.alu_code = ALU_SRL;
          F_SRAV: dec.ctrl.alu_code = ALU_SRA;
          F_ADD:  dec.ctrl.alu_code = ALU_ADD;
          F_ADDU: dec.ctrl.alu_code = ALU_ADDU;
          F_SUB:  dec.ctrl.alu_code = ALU_SUB;
          F_SUBU: dec.ctrl.alu_code = ALU_SUBU;
          F_AND:  dec.ctrl.alu_code = ALU_AND;
          F_OR:   dec.ctrl.alu_code = ALU_OR;
          F_XOR:  dec.ctrl.alu_code = ALU_XOR;
          F_NOR:  dec.ctrl.alu_code = ALU_NOR;
          F_SLT:  dec.ctrl.alu_code = ALU_SLT;
          F_SLTU: dec.ctrl.alu_code = ALU_SLTU;
          default: begin
            dec              = '0;
            dec.ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_BEQ, OP_BNE: begin
        dec.ctrl.alu_code = ALU_SUB;
        dec.ctrl.branch   = (op_s == OP_BEQ) ? BR_EQ : BR_NE;
        dec.imm           = sext16(instr[15:0]);
        dec.uses_rs       = 1'b1;
        dec.uses_rt       = 1'b1;
      end
      OP_ADDI:  dec = itype(ALU_ADD,  sext16(instr[15:0]), instr[20:16]);
      OP_ADDIU: dec = itype(ALU_ADDU, sext16(instr[15:0]), instr[20:16]);
      OP_SLTI:  dec = itype(ALU_SLT,  sext16(instr[15:0]), instr[20:16]);
      OP_SLTIU: dec = itype(ALU_SLTU, sext16(instr[15:0]), instr[20:16]);
      OP_ANDI:  dec = itype(ALU_ANDI, zext16(instr[15:0]), instr[20:16]);
      OP_ORI:   dec = itype(ALU_ORI,  zext16(instr[15:0]), instr[20:16]);
      OP_XORI:  dec = itype(ALU_XORI, zext16(instr[15:0]), instr[20:16]);
      OP_LUI: begin
        dec         = itype(ALU_LUI, zext16(instr[15:0]), instr[20:16]);
        dec.uses_rs = 1'b0;
      end
      OP_LW: begin
        dec               = itype(ALU_ADDU, sext16(instr[15:0]), instr[20:16]);
        dec.ctrl.mem_read = 1'b1;
      end
      OP_SW: begin
        dec                = itype(ALU_ADDU, sext16(instr[15:0]), instr[20:16]);
        dec.ctrl.reg_write = 1'b0;
        dec.ctrl.mem_write = 1'b1;
        dec.uses_rt        = 1'b1;
      end
      default: dec.ctrl.illegal = 1'b1;
    endcase
    // Raw register fields travel with every slot, legal or not
    dec.rs    = instr[25:21];
    dec.rt    = instr[20:16];
    dec.shamt = instr[10:6];
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID stage: decode, load-use hazard detection, handshake and ID/EX register.
module id_ex_decode
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  ex_alu_code,
  output logic        ex_a_sel,
  output logic        ex_b_sel,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal,
  output logic [1:0]  ex_branch,
  output logic [31:0] ex_pc
);

  dec_t        dec_s;
  logic        hazard_s;
  logic        ready_s;

  logic        valid_q, valid_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [31:0] pc_q, pc_d;

  alu_ctrl_decode u_dec (
    .instr (in_instr),
    .dec   (dec_s)
  );

  // Load-use hazard against the lw sitting in EX, and the accept condition
  always_comb begin
    hazard_s = valid_q & ctrl_q.mem_read & (rt_q != 5'd0) &
               ((dec_s.uses_rs & (rt_q == dec_s.rs)) |
                (dec_s.uses_rt & (rt_q == dec_s.rt)));
    ready_s  = ~flush & ~hazard_s & (~valid_q | out_ready);
  end

  // Next ID/EX contents; an emptied slot always carries zero controls
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    pc_d    = pc_q;
    if (flush || (hazard_s && (!valid_q || out_ready))) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (in_valid && ready_s) begin
      valid_d = 1'b1;
      ctrl_d  = dec_s.ctrl;
      imm_d   = dec_s.imm;
      rs_d    = dec_s.rs;
      rt_d    = dec_s.rt;
      rd_d    = dec_s.rd;
      shamt_d = dec_s.shamt;
      pc_d    = in_pc;
    end else if (valid_q && out_ready && !in_valid) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= 32'h0000_0000;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      shamt_q <= 5'd0;
      pc_q    <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      shamt_q <= shamt_d;
      pc_q    <= pc_d;
    end
  end

  assign in_ready     = ready_s;
  assign out_valid    = valid_q;
  assign ex_alu_code  = ctrl_q.alu_code;
  assign ex_a_sel     = ctrl_q.a_sel;
  assign ex_b_sel     = ctrl_q.b_sel;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_illegal   = ctrl_q.illegal;
  assign ex_branch    = ctrl_q.branch;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_shamt     = shamt_q;
  assign ex_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: directed vector table, hand-written stall/hazard/reset
// sequences, and randomized traffic against a table-driven reference model.
module tb_id_ex_decode;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, ex_imm, ex_pc;
  logic [4:0]  ex_alu_code, ex_shamt, ex_rs, ex_rt, ex_rd;
  logic        ex_a_sel, ex_b_sel, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [1:0]  ex_branch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_decode #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ex_alu_code(ex_alu_code), .ex_a_sel(ex_a_sel),
    .ex_b_sel(ex_b_sel), .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal), .ex_branch(ex_branch), .ex_pc(ex_pc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  alu;
    logic        a_sel, b_sel;
    logic [31:0] imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic        rw, mr, mw, ill;
    logic [1:0]  br;
    logic [31:0] pc;
  } ex_t;

  logic [4:0] rfun[int];   // funct -> ALU code for legal R-type
  logic [4:0] iop[int];    // opcode -> ALU code for immediate forms

  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_t r;
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    r = '0;
    r.rs = ins[25:21]; r.rt = ins[20:16]; r.shamt = ins[10:6]; r.pc = pc;
    if (op == 0) begin
      if (rfun.exists(fn)) begin
        r.alu   = rfun[fn];
        r.a_sel = (fn == 0 || fn == 2 || fn == 3);
        r.rd    = ins[15:11];
        r.rw    = (ins[15:11] != 0);
      end else r.ill = 1'b1;
    end else if (op == 4 || op == 5) begin
      r.alu = 5'b00101;
      r.br  = (op == 4) ? 2'b01 : 2'b10;
      r.imm = 32'($signed(ins[15:0]));
    end else if (iop.exists(op)) begin
      r.alu   = iop[op];
      r.b_sel = 1'b1;
      r.rd    = ins[20:16];
      r.imm   = (op >= 12 && op <= 15) ? {16'h0, ins[15:0]} : 32'($signed(ins[15:0]));
      r.mr    = (op == 35);
      r.mw    = (op == 43);
      r.rw    = (op != 43);
    end else r.ill = 1'b1;
    return r;
  endfunction

  function automatic void uses_of(input logic [31:0] ins, output bit urs, output bit urt);
    int op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    urs = 0; urt = 0;
    if (op == 0) begin
      if (rfun.exists(fn)) begin urs = !(fn == 0 || fn == 2 || fn == 3); urt = 1; end
    end else if (op == 4 || op == 5 || op == 43) begin
      urs = 1; urt = 1;
    end else if (iop.exists(op)) begin
      urs = (op != 15);
    end
  endfunction

  function automatic ex_t clr_ctrl(input ex_t e);
    ex_t r;
    r = e;
    r.alu = '0; r.a_sel = 0; r.b_sel = 0; r.rw = 0; r.mr = 0; r.mw = 0; r.ill = 0; r.br = '0;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    int ops[16] = '{0, 0, 0, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 63};
    int fns[18] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 1, 63};
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] lo;
    op = 6'(ops[$urandom_range(0, 15)]);
    fn = 6'(fns[$urandom_range(0, 17)]);
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    sh = 5'($urandom_range(0, 31));
    lo = (op == 6'd0) ? {rd, sh, fn} : 16'($urandom);
    return {op, rs, rt, lo};
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  alu;
    logic        a_sel, b_sel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, ill;
    logic [1:0]  br;
  } vec_t;

  vec_t vt[17];
  ex_t  m;
  bit   mv, urs, urt, hz, rdy;

  initial begin
    rfun[0] = 5'b10000; rfun[2] = 5'b10001; rfun[3] = 5'b10010;
    rfun[4] = 5'b10000; rfun[6] = 5'b10001; rfun[7] = 5'b10010;
    rfun[32] = 5'b00000; rfun[33] = 5'b10101; rfun[34] = 5'b00101; rfun[35] = 5'b10110;
    rfun[36] = 5'b00001; rfun[37] = 5'b00011; rfun[38] = 5'b00010; rfun[39] = 5'b00100;
    rfun[42] = 5'b10011; rfun[43] = 5'b10100;
    iop[8] = 5'b00000; iop[9] = 5'b10101; iop[10] = 5'b10011; iop[11] = 5'b10100;
    iop[12] = 5'b00110; iop[13] = 5'b01000; iop[14] = 5'b00111; iop[15] = 5'b10111;
    iop[35] = 5'b10101; iop[43] = 5'b10101;

    //          instr          alu       a  b  imm           rd  rw mr mw il br
    vt[0]  = '{32'h00221820, 5'b00000, 0, 0, 32'h00000000, 3, 1, 0, 0, 0, 2'b00}; // add
    vt[1]  = '{32'h00011100, 5'b10000, 1, 0, 32'h00000000, 2, 1, 0, 0, 0, 2'b00}; // sll 4
    vt[2]  = '{32'h3C051234, 5'b10111, 0, 1, 32'h00001234, 5, 1, 0, 0, 0, 2'b00}; // lui
    vt[3]  = '{32'h2021FFFF, 5'b00000, 0, 1, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 2'b00}; // addi -1
    vt[4]  = '{32'h3021FFFF, 5'b00110, 0, 1, 32'h0000FFFF, 1, 1, 0, 0, 0, 2'b00}; // andi
    vt[5]  = '{32'hFC000000, 5'b00000, 0, 0, 32'h00000000, 0, 0, 0, 0, 1, 2'b00}; // op 3F
    vt[6]  = '{32'h8C240000, 5'b10101, 0, 1, 32'h00000000, 4, 1, 1, 0, 0, 2'b00}; // lw
    vt[7]  = '{32'hAC240008, 5'b10101, 0, 1, 32'h00000008, 4, 0, 0, 1, 0, 2'b00}; // sw
    vt[8]  = '{32'h10220003, 5'b00101, 0, 0, 32'h00000003, 0, 0, 0, 0, 0, 2'b01}; // beq
    vt[9]  = '{32'h1422FFFE, 5'b00101, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 2'b10}; // bne
    vt[10] = '{32'h00221804, 5'b10000, 0, 0, 32'h00000000, 3, 1, 0, 0, 0, 2'b00}; // sllv
    vt[11] = '{32'h00220020, 5'b00000, 0, 0, 32'h00000000, 0, 0, 0, 0, 0, 2'b00}; // add $0
    vt[12] = '{32'h2C41FFFF, 5'b10100, 0, 1, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 2'b00}; // sltiu
    vt[13] = '{32'h0000003F, 5'b00000, 0, 0, 32'h00000000, 0, 0, 0, 0, 1, 2'b00}; // bad funct
    vt[14] = '{32'h00011143, 5'b10010, 1, 0, 32'h00000000, 2, 1, 0, 0, 0, 2'b00}; // sra 5
    vt[15] = '{32'h342200F0, 5'b01000, 0, 1, 32'h000000F0, 2, 1, 0, 0, 0, 2'b00}; // ori
    vt[16] = '{32'h38228000, 5'b00111, 0, 1, 32'h00008000, 2, 1, 0, 0, 0, 2'b00}; // xori

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu", ex_alu_code, 0);
    chk("rst_ctrl", {ex_a_sel, ex_b_sel, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, ex_branch}, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_regs", {ex_rs, ex_rt, ex_rd, ex_shamt}, 0);
    chk("rst_pc", ex_pc, RPC);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // Directed vectors, each followed by one drain cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_alu", i), ex_alu_code, vt[i].alu);
      chk($sformatf("vec%0d_sel", i), {ex_a_sel, ex_b_sel}, {vt[i].a_sel, vt[i].b_sel});
      chk($sformatf("vec%0d_imm", i), ex_imm, vt[i].imm);
      chk($sformatf("vec%0d_rd", i), ex_rd, vt[i].rd);
      chk($sformatf("vec%0d_rs_rt_sh", i), {ex_rs, ex_rt, ex_shamt},
          {vt[i].instr[25:21], vt[i].instr[20:16], vt[i].instr[10:6]});
      chk($sformatf("vec%0d_ctl", i), {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, ex_branch},
          {vt[i].rw, vt[i].mr, vt[i].mw, vt[i].ill, vt[i].br});
      chk($sformatf("vec%0d_pc", i), ex_pc, 32'h1000 + 32'(i * 4));
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drain", i), {out_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    end

    // Load-use: lw $4 then add $5,$4,$4 -> exactly one bubble
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h8C240000; in_pc = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    in_instr = 32'h00842820; in_pc = 32'h2004;
    #1 chk("lu_stall_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("lu_bubble_valid", out_valid, 0);
    chk("lu_bubble_mr", ex_mem_read, 0);
    @(negedge clk);
    #1 chk("lu_resume_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_fields", {ex_alu_code, ex_rd, ex_pc}, {5'b00000, 5'd5, 32'h2004});
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);

    // Back-pressure for 3 cycles, then flush during the stall
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h3000;
    @(posedge clk); #1 chk("stall_load", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'h3021FFFF; in_pc = 32'h3004;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_ready", c), in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_hold", c), {out_valid, ex_alu_code, ex_rd, ex_b_sel, ex_pc},
          {1'b1, 5'b00000, 5'd3, 1'b0, 32'h3000});
      @(negedge clk);
    end
    flush = 1'b1;
    #1 chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("flush_valid", {out_valid, ex_reg_write}, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Async reset in the middle of a load-use stall
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h8C240000;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'h00842820;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ctrl", {ex_alu_code, ex_mem_read, ex_reg_write, ex_b_sel}, 0);
    chk("arst_pc", ex_pc, RPC);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("arst_no_stale_hazard", in_ready, 1);
    @(posedge clk); #1 chk("arst_restart", {out_valid, ex_rd}, {1'b1, 5'd5});
    @(negedge clk);
    in_valid = 1'b0;

    // Randomized traffic against the reference model, from a clean reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = '0; m.pc = RPC; mv = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      #1;
      uses_of(in_instr, urs, urt);
      hz  = mv && m.mr && (m.rt != 0) &&
            ((urs && m.rt == in_instr[25:21]) || (urt && m.rt == in_instr[20:16]));
      rdy = !flush && !hz && (!mv || out_ready);
      chk("rand_in_ready", in_ready, rdy);
      @(posedge clk); #1;
      if (flush || (hz && (!mv || out_ready))) begin
        mv = 0; m = clr_ctrl(m);
      end else if (in_valid && rdy) begin
        mv = 1; m = ref_decode(in_instr, in_pc);
      end else if (mv && out_ready && !in_valid) begin
        mv = 0; m = clr_ctrl(m);
      end
      chk("rand_valid", out_valid, mv);
      chk("rand_ctrl", {ex_alu_code, ex_a_sel, ex_b_sel, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, ex_branch},
          {m.alu, m.a_sel, m.b_sel, m.rw, m.mr, m.mw, m.ill, m.br});
      chk("rand_imm", ex_imm, m.imm);
      chk("rand_regs", {ex_rs, ex_rt, ex_rd, ex_shamt}, {m.rs, m.rt, m.rd, m.shamt});
      chk("rand_pc", ex_pc, m.pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_decode.md
# id_ex_decode

Instruction decode stage and ID/EX pipeline register for the pipelined MIPS core; the producer side of the 5-bit ALU operation code consumed in EX. Each cycle it accepts one fetched instruction and decodes opcode/funct into an ALU code, operand selects, immediate and writeback/memory controls. It registers the result into EX with a valid/ready handshake, load-use bubble insertion and flush.

## Interface
- `RESET_PC`, default 32'h0000_0000: reset value of `ex_pc`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  IF/ID holds an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  its PC.
- `flush`  in  1  discard the ID instruction and the ID/EX contents.
- `out_valid`  out  1  ID/EX holds a real instruction.
- `out_ready`  in  1  EX consumes ID/EX this cycle.
- `ex_alu_code`  out  5  ALU operation code.
- `ex_a_sel`  out  1  0 = rs data, 1 = zero-extended shamt.
- `ex_b_sel`  out  1  0 = rt data, 1 = `ex_imm`.
- `ex_imm`  out  32  extended immediate.
- `ex_shamt`, `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  shamt, source regs, destination reg.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_illegal`  out  1 each.
- `ex_branch`  out  2  00 none, 01 beq, 10 bne.
- `ex_pc`  out  32.

## Operation
- ALU codes: add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101, andi 00110, xori 00111, ori 01000, sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100, addu 10101, subu 10110, lui 10111.
- Shift semantics: the ALU shifts B by A.
  - sll/srl/sra (funct 00/02/03): `a_sel`=1.
  - sllv/srlv/srav (04/06/07): `a_sel`=0, with the same codes.
- R-type (op 0) funct map: 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu. `rd`=instr[15:11], `reg_write`=1 (0 if rd=0).
- I-type (`b_sel`=1, `rd`=instr[20:16]):
  - Sign-extended immediate: 08 addi→add, 09 addiu→addu, 0A slti→slt, 0B sltiu→sltu, 23 lw→addu (`mem_read`), 2B sw→addu (`mem_write`, no reg_write).
  - Zero-extended immediate: 0C andi, 0D ori, 0E xori, 0F lui.
- Branches: 04 beq, 05 bne → sub, `b_sel`=0, `branch` set, no reg_write.
- Any other opcode/funct:
  - `illegal`=1, alu_code 00000, all write/memory controls 0.
  - Still a valid slot, so EX can raise an exception.
- Load-use hazard: `out_valid & ex_mem_read & ex_rt!=0 & (ex_rt==instr rs if rs used | ex_rt==instr rt if rt used as source)`.
  - rs is unused by lui and by the shamt shifts.
  - rt is a source for R-type, sw and branches.
- `in_ready = !flush & !hazard & (!out_valid | out_ready)`.

## Timing
- Reset (async, immediate):
  - `out_valid`=0 and all control outputs 0.
  - `ex_alu_code`=00000, `ex_imm`/registers 0, `ex_pc`=`RESET_PC`.
- Latency is 1 cycle: an instruction accepted at edge N appears on the `ex_*` outputs after edge N.
- ID/EX update at each edge, in priority order:
  - `flush`: `out_valid`←0 and the ID instruction is dropped. Flush takes precedence over all other conditions.
  - hazard & (`!out_valid` | `out_ready`): bubble, `out_valid`←0 with all controls 0. The ID instruction is held by its producer and accepted on a later cycle.
  - `in_valid & in_ready`: load the decoded instruction, `out_valid`←1.
  - `out_valid & out_ready & !in_valid`: `out_valid`←0.
  - otherwise: hold all registers.
- Bubble-out uses the same path as flush: when `out_valid`=0, every write/memory/branch control is 0.
- The hazard produces exactly one bubble per lw, because the bubble clears `ex_mem_read` after one cycle.
- Reset deasserted mid-stall: restarts empty, with no stale hazard.

## Structure
- Shared package `mips_pkg`:
  - ALU code localparams; opcode and funct constants.
  - Branch encoding.
- Sub-module `alu_ctrl_decode`: pure combinational decode of `in_instr` to a control bundle.
- Top level `id_ex_decode`: hazard detection, handshake and pipeline register.

## Test plan
- 0x00221820 (add $3,$1,$2) → `ex_alu_code`=00000, rs=1, rt=2, rd=3, `reg_write`=1, `b_sel`=0, `out_valid`=1 one cycle later.
- 0x00011100 (sll $2,$1,4) → alu_code 10000, `a_sel`=1, `shamt`=4, rd=2. 0x3C051234 (lui $5,0x1234) → 10111, `b_sel`=1, `imm`=0x00001234, rd=5.
- 0x8C240000 (lw) then 0x00842820 (add $5,$4,$4) → exactly one bubble (`out_valid`=0, `in_ready`=0 for one cycle), then the add is issued.
- 0x2021FFFF (addi $1,$1,-1) → alu_code 00000, `imm`=0xFFFFFFFF. 0x3021FFFF (andi) → 00110, `imm`=0x0000FFFF.
- `out_ready`=0 for 3 cycles with `in_valid`=1 → `ex_*` stable and `in_ready`=0; `flush` during that stall → `out_valid`=0 next cycle.
- Opcode 0x3F → `ex_illegal`=1, write/memory controls 0. `rst_n` low mid-stream → `out_valid` drops to 0 asynchronously.
